// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_pkg
//  Purpose  : Shared definitions for the keyboard event scheduler: ps2_key
//             event field offsets, the Shift scancode, the scheduler state
//             encoding, the injected-character entry layout and an event
//             builder helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package kbd_pkg;

  // ps2_key event layout: [10] strobe toggle, [9] pressed, [8] extended,
  // [7:0] scancode
  localparam int STB = 10;
  localparam int PRS = 9;
  localparam int EXT = 8;

  localparam logic [7:0] SC_LSHIFT = 8'h12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_DN = 3'd1,
    ST_KEY_DN   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_KEY_UP   = 3'd4,
    ST_SHIFT_UP = 3'd5,
    ST_GAP      = 3'd6
  } sched_state_t;

  typedef struct packed {
    logic       shift;
    logic       ext;
    logic [7:0] code;
  } inj_entry_t;

  localparam int INJ_W = $bits(inj_entry_t);

  // Build the 10-bit payload of an event (everything except the strobe).
  function automatic logic [PRS:0] mk_event(input logic       pressed,
                                            input logic       ext,
                                            input logic [7:0] code);
    logic [PRS:0] ev;
    ev      = '0;
    ev[PRS] = pressed;
    ev[EXT] = ext;
    ev[7:0] = code;
    return ev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_inj_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_inj_fifo
//  Purpose  : Synchronous FIFO for injected characters with flush.
//             Full/empty are derived from read/write pointers carrying one
//             extra wrap bit. Push is ignored when full, pop when empty, and
//             both are ignored while flush is asserted.
//  Ports    : clk, reset (async, active-high), flush, push, din, pop,
//             dout (head entry, valid when !empty), full, empty
//  Revision : 1.0 - initial release
// ============================================================================
module kbd_inj_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      // Collapse to empty; the storage contents are simply abandoned.
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/kbd_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_event_scheduler
//  Purpose  : Merges live PS/2 key events with a queued stream of injected
//             characters into one ps2_key-format event stream. Injected
//             characters become timed press/hold/release sequences, wrapped
//             in Left-Shift press/release when requested. Live events always
//             win a same-cycle collision; the scheduler retries next cycle.
//  Ports    : clk, reset (async, active-high)
//             ps2_key_in[10:0]  live events (strobe toggle, pressed, ext, code)
//             inj_valid/inj_data[9:0]/inj_ready  injected char handshake
//             abort             flush queue and release any injected key
//             ps2_key_out[10:0] merged event stream
//             busy              queue non-empty or sequence in progress
//  Revision : 1.0 - initial release
// ============================================================================
module kbd_event_scheduler
  import kbd_pkg::*;
#(
  parameter logic [15:0] HOLD_CYCLES = 16'd50000,
  parameter logic [15:0] GAP_CYCLES  = 16'd50000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key_in,
  input  logic        inj_valid,
  input  logic [9:0]  inj_data,
  output logic        inj_ready,
  input  logic        abort,
  output logic [10:0] ps2_key_out,
  output logic        busy
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? int'(HOLD_CYCLES) : int'(GAP_CYCLES);
  localparam int TW         = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

  // Press-to-release spacing is HOLD_CYCLES: the KEY_DN->HOLD and
  // HOLD->KEY_UP transitions each consume one of those cycles.
  localparam logic [TW-1:0] HOLD_LOAD = (HOLD_CYCLES > 16'd2) ? TW'(HOLD_CYCLES - 16'd2) : '0;
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES);

  sched_state_t   state;
  inj_entry_t     cur;
  inj_entry_t     head;
  logic [TW-1:0]  timer;
  logic           stb_seen;
  logic           live;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;
  logic [INJ_W-1:0] fifo_dout;
  logic           want_emit;
  logic           fire;
  logic [PRS:0]   fsm_event;

  // Plain tracking register: it follows the strobe every cycle, including
  // while reset is held, so at reset release it already holds the current
  // strobe level and no spurious live event is seen.
  always_ff @(posedge clk) begin
    stb_seen <= ps2_key_in[STB];
  end

  assign live      = (ps2_key_in[STB] != stb_seen);
  assign inj_ready = ~fifo_full;
  assign fifo_push = inj_valid & inj_ready;
  assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty & (timer == '0) & ~abort;
  assign head      = inj_entry_t'(fifo_dout);
  assign busy      = ~fifo_empty | (state != ST_IDLE);

  kbd_inj_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INJ_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (fifo_push),
    .din   (inj_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Event the sequencer would like to emit this cycle. Abort in SHIFT_DN or
  // KEY_DN skips the pending press and jumps straight to the release path.
  always_comb begin
    want_emit = 1'b0;
    fsm_event = '0;
    case (state)
      ST_SHIFT_DN: begin
        want_emit = ~abort;
        fsm_event = mk_event(1'b1, 1'b0, SC_LSHIFT);
      end
      ST_KEY_DN: begin
        want_emit = ~abort;
        fsm_event = mk_event(1'b1, cur.ext, cur.code);
      end
      ST_KEY_UP: begin
        want_emit = 1'b1;
        fsm_event = mk_event(1'b0, cur.ext, cur.code);
      end
      ST_SHIFT_UP: begin
        want_emit = 1'b1;
        fsm_event = mk_event(1'b0, 1'b0, SC_LSHIFT);
      end
      default: begin
        want_emit = 1'b0;
        fsm_event = '0;
      end
    endcase
  end

  assign fire = want_emit & ~live;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur         <= '0;
      timer       <= '0;
      ps2_key_out <= '0;
    end else begin
      if (live) begin
        ps2_key_out <= {~ps2_key_out[STB], ps2_key_in[PRS:0]};
      end else if (fire) begin
        ps2_key_out <= {~ps2_key_out[STB], fsm_event};
      end

      if (timer != '0) timer <= timer - TW'(1);
      // Live typing pushes the next injected character back, but never
      // stretches a key that is already being held.
      if (live && (state == ST_IDLE || state == ST_GAP)) timer <= GAP_LOAD;

      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            cur   <= head;
            state <= head.shift ? ST_SHIFT_DN : ST_KEY_DN;
          end
        end
        ST_SHIFT_DN: begin
          if (abort)     state <= ST_SHIFT_UP;
          else if (fire) state <= ST_KEY_DN;
        end
        ST_KEY_DN: begin
          if (abort) begin
            state <= ST_KEY_UP;
          end else if (fire) begin
            timer <= HOLD_LOAD;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (abort || timer == '0) state <= ST_KEY_UP;
        end
        ST_KEY_UP: begin
          if (fire) state <= cur.shift ? ST_SHIFT_UP : ST_GAP;
        end
        ST_SHIFT_UP: begin
          if (fire) state <= ST_GAP;
        end
        ST_GAP: begin
          timer <= GAP_LOAD;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_event_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_kbd_event_scheduler
//  Purpose  : Scoreboard bench for kbd_event_scheduler (HOLD=4, GAP=4,
//             FIFO depth 8). Stimulus pushes expected events into a queue;
//             a monitor pops and compares on every output strobe toggle.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_event_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key_in;
  logic        inj_valid;
  logic [9:0]  inj_data;
  logic        inj_ready;
  logic        abort;
  logic [10:0] ps2_key_out;
  logic        busy;

  always #5 clk = ~clk;

  kbd_event_scheduler #(
    .HOLD_CYCLES (16'd4),
    .GAP_CYCLES  (16'd4),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_key_in  (ps2_key_in),
    .inj_valid   (inj_valid),
    .inj_data    (inj_data),
    .inj_ready   (inj_ready),
    .abort       (abort),
    .ps2_key_out (ps2_key_out),
    .busy        (busy)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cycle = 0;
  logic [9:0] exp_q[$];
  int         ev_cyc[$];
  logic       prev_stb = 1'b0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: every strobe toggle is one event, checked in order.
  always @(negedge clk) begin
    if (reset) begin
      prev_stb = ps2_key_out[10];
    end else if (ps2_key_out[10] !== prev_stb) begin
      prev_stb = ps2_key_out[10];
      ev_cyc.push_back(cycle);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: got 0x%0h, expected none (cycle %0d)", ps2_key_out[9:0], cycle);
      end else begin
        check("event", 32'(ps2_key_out[9:0]), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_char(input logic [9:0] d, input bit add_exp);
    int g = 0;
    inj_data  = d;
    inj_valid = 1'b1;
    while (!inj_ready && g < 200) begin
      tick();
      g++;
    end
    check("inj_ready_wait", 32'(inj_ready), 32'd1);
    if (add_exp) begin
      if (d[9]) exp_q.push_back(10'h212);
      exp_q.push_back({1'b1, d[8:0]});
      exp_q.push_back({1'b0, d[8:0]});
      if (d[9]) exp_q.push_back(10'h012);
    end
    tick();
    inj_valid = 1'b0;
  endtask

  task automatic wait_events(input string name, input int n, input int budget);
    int g = 0;
    while (ev_cyc.size() < n && g < budget) begin
      tick();
      g++;
    end
    check(name, 32'(ev_cyc.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < budget) begin
      tick();
      g++;
    end
    check(name, 32'(exp_q.size() == 0 && !busy), 32'd1);
    repeat (10) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] fill_codes [9];
  int base, acc, ab_cyc, fall_cyc, rise_cyc, g;

  initial begin
    fill_codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B};
    reset      = 1'b0;
    ps2_key_in = 11'h000;
    inj_valid  = 1'b0;
    inj_data   = 10'h000;
    abort      = 1'b0;
    #1 reset = 1'b1;
    repeat (3) tick();

    // Reset state
    check("reset_out", 32'(ps2_key_out), 32'h0);
    check("reset_ready", 32'(inj_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // 1: plain character, press then release 4 cycles later
    base = ev_cyc.size();
    send_char(10'h01C, 1'b1);
    g = 0;
    while (busy && g < 60) begin
      tick();
      g++;
    end
    fall_cyc = cycle;
    check("t1_events", 32'(ev_cyc.size() - base), 32'd2);
    check("t1_hold_spacing", 32'(ev_cyc[base+1] - ev_cyc[base]), 32'd4);
    check("t1_busy_fall", 32'(fall_cyc - ev_cyc[base+1]), 32'd1);
    repeat (10) tick();

    // 2: shifted character, shift events adjacent to key events
    base = ev_cyc.size();
    send_char(10'h224, 1'b1);
    wait_events("t2_wait", base + 4, 60);
    check("t2_shift_dn_gap", 32'(ev_cyc[base+1] - ev_cyc[base]), 32'd1);
    check("t2_hold_spacing", 32'(ev_cyc[base+2] - ev_cyc[base+1]), 32'd4);
    check("t2_shift_up_gap", 32'(ev_cyc[base+3] - ev_cyc[base+2]), 32'd1);
    wait_idle("t2_idle", 60);

    // 3: live event collides with the scheduled KEY_DN emission
    base = ev_cyc.size();
    send_char(10'h01C, 1'b0);
    tick();
    ps2_key_in = {~ps2_key_in[10], 1'b1, 1'b0, 8'h15};
    exp_q.push_back(10'h215);
    exp_q.push_back(10'h21C);
    exp_q.push_back(10'h01C);
    wait_events("t3_wait", base + 3, 40);
    check("t3_retry_spacing", 32'(ev_cyc[base+1] - ev_cyc[base]), 32'd1);
    check("t3_hold_spacing", 32'(ev_cyc[base+2] - ev_cyc[base+1]), 32'd4);
    wait_idle("t3_idle", 60);

    // 4: fill the FIFO while the sequencer is occupied
    base = ev_cyc.size();
    send_char(10'h01C, 1'b1);
    acc = 0;
    g   = 0;
    inj_valid = 1'b1;
    while (acc < 9 && g < 40) begin
      inj_data = {2'b00, fill_codes[acc]};
      if (!inj_ready) break;
      exp_q.push_back({2'b10, fill_codes[acc]});
      exp_q.push_back({2'b00, fill_codes[acc]});
      acc++;
      g++;
      tick();
    end
    check("t4_fill_count", 32'(acc), 32'd8);
    check("t4_ready_low", 32'(inj_ready), 32'd0);
    g = 0;
    while (!inj_ready && g < 40) begin
      tick();
      g++;
    end
    inj_valid = 1'b0;
    rise_cyc  = cycle;
    check("t4_ready_rise", 32'(inj_ready), 32'd1);
    wait_events("t4_wait_pop", base + 3, 20);
    check("t4_rise_to_press", 32'(ev_cyc[base+2] - rise_cyc), 32'd1);
    wait_idle("t4_idle", 400);

    // 5: abort during HOLD of a shifted character; queued char is flushed
    base = ev_cyc.size();
    send_char(10'h22C, 1'b1);
    send_char(10'h01B, 1'b0);
    wait_events("t5_wait_press", base + 2, 40);
    abort  = 1'b1;
    ab_cyc = cycle;
    tick();
    abort = 1'b0;
    wait_events("t5_wait_release", base + 4, 20);
    check("t5_abort_to_release", 32'(ev_cyc[base+2] - ab_cyc), 32'd2);
    check("t5_shift_up_gap", 32'(ev_cyc[base+3] - ev_cyc[base+2]), 32'd1);
    wait_idle("t5_idle", 40);
    repeat (20) tick();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_no_extra", 32'(ev_cyc.size() - base), 32'd4);

    // 6: asynchronous reset in the middle of HOLD
    base = ev_cyc.size();
    send_char(10'h01C, 1'b1);
    wait_events("t6_wait_press", base + 1, 40);
    tick();
    check("t6_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_out", 32'(ps2_key_out), 32'h0);
    check("t6_ready", 32'(inj_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("t6_no_release", 32'(ev_cyc.size() - base), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kbd_event_scheduler.md
Name: kbd_event_scheduler

Overview:
- Sits between the PS/2 decoder and the Ondra keyboard matrix block.
- Merges live PS/2 key events with an injected key stream (auto-type of loader commands, paste) into one ps2_key-format event stream.
- Injected characters are sequenced as timed press/hold/release events, with optional Shift wrapping.
- Live events always take priority.

Parameters:
- HOLD_CYCLES, 16'd50000, clk cycles between an injected key's press and its release.
- GAP_CYCLES, 16'd50000, clk cycles of quiet after an injected character, and after any live event, before the next injected character starts.
- FIFO_DEPTH, 8, injected-character FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_key_in  in  11  live event: [10] strobe toggle, [9] pressed, [8] extended, [7:0] scancode
- inj_valid  in  1  injected character offered
- inj_data  in  10  [9] needs Shift, [8] extended, [7:0] scancode
- inj_ready  out  1  FIFO not full; a transfer occurs when inj_valid & inj_ready
- abort  in  1  flush the FIFO and release any injected key cleanly
- ps2_key_out  out  11  merged event stream, same format as ps2_key_in
- busy  out  1  FIFO non-empty, or FSM not in IDLE

Behaviour:
- Reset: ps2_key_out=0, FIFO empty, FSM=IDLE, timer=0, inj_ready=1, busy=0. The stored copy of ps2_key_in[10] loads its current value.
- Emission: one event per cycle maximum. Each event is registered into ps2_key_out[9:0] and ps2_key_out[10] is inverted in the same cycle. Latency from live strobe toggle to output toggle is 1 cycle.
- Live path: a change of ps2_key_in[10] versus its stored copy is a live event. Forward [9:0] unchanged and reload the quiet timer with GAP_CYCLES.
- Priority collision: if a live event and an FSM emission fall in the same cycle, the live event is emitted. The FSM holds its state and retries the emission next cycle.
- FSM states and transitions:
  - IDLE: when FIFO is non-empty and the timer is 0, pop the head and go to SHIFT_DN if bit 9 is set, else KEY_DN.
  - SHIFT_DN: emit press of 0x12, extended=0; go to KEY_DN.
  - KEY_DN: emit press of {ext, code}; load timer=HOLD_CYCLES; go to HOLD.
  - HOLD: wait for timer=0; go to KEY_UP.
  - KEY_UP: emit release of {ext, code}; go to SHIFT_UP if the character was shifted, else GAP.
  - SHIFT_UP: emit release of 0x12; go to GAP.
  - GAP: load timer=GAP_CYCLES; go to IDLE.
- Timer: single down-counter, width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). Saturates at 0. A live event reloads it only in IDLE or GAP, never in HOLD.
- FIFO:
  - Push when inj_valid & inj_ready. Pop on IDLE exit.
  - Simultaneous push and pop when full is not allowed: inj_ready is deasserted when full, regardless of a pop in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are detected with an extra pointer bit.
- abort (level, sampled each cycle):
  - Clears the FIFO in the same cycle; a push in that cycle is dropped.
  - In HOLD or KEY_DN: go directly to KEY_UP, then complete SHIFT_UP if applicable, so no key is left pressed.
  - In SHIFT_DN: go to SHIFT_UP.
  - In IDLE or GAP: no effect beyond the flush.
- Reset mid-operation: no release events are generated. The downstream keyboard block clears its matrix on the same reset.
- busy: combinational from FIFO-empty and FSM state.

Decomposition:
- Shared package kbd_pkg holds:
  - event field offsets (STB=10, PRS=9, EXT=8)
  - SC_LSHIFT=8'h12
  - FSM state enum
  - typedef inj_entry_t {shift, ext, code[7:0]}
- One sub-module: kbd_inj_fifo, a parameterised synchronous FIFO with full/empty outputs and a flush input.

Test Plan:
1. Push {0,0,8'h1C} with HOLD=4, GAP=4 → output events press 1C, then release 1C exactly 4 cycles later. [10] toggles twice. busy stays high until GAP ends.
2. Push {1,0,8'h24} → event order: press 12, press 24, release 24, release 12. Each Shift event is adjacent to its key event (1 cycle apart).
3. Live toggle {p=1, 8'h15} arriving in the same cycle as the scheduled KEY_DN → live 15 emitted first, injected press emitted the following cycle. No event is lost.
4. Hold inj_valid high with the FSM blocked by GAP → inj_ready drops after FIFO_DEPTH (8) accepted pushes, and rises 1 cycle after the first pop.
5. Assert abort during HOLD of a shifted character → release of the key, then release of 12, in the next 2 emission cycles. FIFO is empty and busy=0 after GAP.
6. Assert reset mid-HOLD → ps2_key_out=0, inj_ready=1, busy=0 immediately (asynchronously). No release is emitted after reset deasserts.
